sram_stream_writer: RTL and testbench
=====================================

// Module: sram_stream_writer
// PURPOSE
//   Upstream loader for the 32x256 1RW1R SRAM unit. Accepts a valid/ready byte
//   stream, packs bytes little-endian into DATA_WIDTH words and issues
//   byte-masked writes on SRAM port 0 (csb0/web0/wmask0/addr0/din0) at
//   sequential addresses from 0. Assert done before releasing csb1 so the
//   port-1 address counter streams a fully loaded memory.
// PARAMETERS
//   DATA_WIDTH  32  SRAM word width; must equal 8*NUM_WMASKS
//   ADDR_WIDTH  8   SRAM address width; depth = 2**ADDR_WIDTH
//   NUM_WMASKS  4   bytes per word / write-mask bits
// PORTS
//   clk            in   1             clock
//   rst_n          in   1             reset, synchronous, active-low
//   start          in   1             pulse: begin new load at addr 0 (honoured only in IDLE/DONE)
//   in_valid       in   1             byte valid
//   in_data        in   8             byte payload
//   in_last        in   1             final byte of stream; flushes partial word
//   in_ready       out  1             byte accepted when in_valid & in_ready
//   csb0           out  1             SRAM chip select, active low (registered)
//   web0           out  1             SRAM write enable, active low (registered)
//   wmask0         out  NUM_WMASKS    byte write mask (registered)
//   addr0          out  ADDR_WIDTH    write address (registered)
//   din0           out  DATA_WIDTH    write data (registered)
//   words_written  out  ADDR_WIDTH+1  words committed since last start
//   done           out  1             load complete; held until next start
//   full           out  1             stopped at last address (no-wrap build only)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE; csb0=1, web0=1, wmask0=0, addr0=0,
//     din0=0, in_ready=0, words_written=0, done=0, full=0; partial word discarded.
//   FSM IDLE -> FILL -> WRITE -> {FILL | DONE}; DONE -> FILL on start.
//   IDLE: in_ready=0. start -> FILL; wr_addr=0, lane=0, mask=0, words_written=0.
//   FILL: in_ready=1. On handshake byte goes to lane `lane` (bits 8*lane+:8), mask[lane]=1.
//     lane==NUM_WMASKS-1 or in_last -> WRITE (latch last flag); else lane++.
//   WRITE (1 cycle): in_ready=0; csb0=0, web0=0, addr0=wr_addr, din0=buffer,
//     wmask0=mask, all registered, so strobe is active the cycle after the final
//     byte handshake; SRAM samples it at the following edge. Unmasked lanes of din0 = 0.
//     Next: csb0=1, web0=1, wmask0=0, wr_addr++, words_written++, lane=0, mask=0.
//     last flag -> DONE; else wr_addr was 2**ADDR_WIDTH-1 -> see CONFIGURATION; else FILL.
//   DONE: done=1, in_ready=0; start clears done/full/words_written, wr_addr=0, -> FILL.
//   Throughput: one full word per NUM_WMASKS+1 cycles with in_valid held high.
//   start outside IDLE/DONE ignored. in_last on lane NUM_WMASKS-1 -> single full-mask write.
//   in_valid=0 in FILL: state/buffer held, no SRAM access (csb0=1).
//   Reset mid-FILL/WRITE: abort; in-flight strobe deasserted the same edge.
// CONFIGURATION
//   SRAM_WRITER_WRAP_EN defined: after address 2**ADDR_WIDTH-1 wr_addr wraps to 0
//     and FILL continues; full stays 0; words_written saturates at 2**ADDR_WIDTH.
//   Undefined: write to address 2**ADDR_WIDTH-1 without in_last -> DONE with
//     done=1, full=1; further bytes not accepted (in_ready=0).
// TESTING
//   start; bytes 11,22,33,44 back-to-back -> 1 cycle later csb0=0,web0=0,addr0=0,
//     din0=0x44332211, wmask0=4'hF; done=1, words_written=1 only if 44 had in_last.
//   5 bytes AA..EE, in_last on EE -> write@0 din0=0xDDCCBBAA mask F; write@1
//     din0=0x000000EE mask 4'b0001; done=1, words_written=2.
//   Random in_valid gaps over 8 words -> addr0 0..7 in order, data matches model,
//     csb0 low exactly 8 cycles, never low in IDLE/FILL.
//   1024 bytes no in_last, no WRAP_EN -> 256 writes, full=1, done=1, in_ready=0;
//     with WRAP_EN -> 257th word written at addr0=0, full=0, words_written=256.
//   rst_n=0 after 2 bytes of a word -> next cycle csb0=1, in_ready=0, IDLE; after
//     start, first write at addr 0 contains only post-reset bytes.
//   start pulsed during FILL -> ignored (addr sequence unbroken); start in DONE ->
//     done=0, words_written=0, next write at addr0=0.

Source files
------------

// File: rtl/sram_stream_writer.sv
// Byte-stream loader for the 32x256 1RW1R SRAM: packs bytes little-endian into words
// and issues byte-masked writes on port 0. Optional SRAM_WRITER_WRAP_EN wraps the address.
module sram_stream_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  done,
  output logic                  full
);

  localparam int unsigned LANE_W = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [CNT_W-1:0]      WORDS_MAX = CNT_W'(1) << ADDR_WIDTH;
  localparam logic [LANE_W-1:0]     LANE_MAX  = LANE_W'(NUM_WMASKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [NUM_WMASKS-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]        words_q, words_d;
  logic                    done_q, done_d;
  logic                    full_q, full_d;
  logic                    in_ready_q, in_ready_d;
  logic                    csb0_q, csb0_d;
  logic                    web0_q, web0_d;
  logic [NUM_WMASKS-1:0]   wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0]   din0_q, din0_d;
  logic                    accept;

  assign accept = in_valid & in_ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and SRAM strobe decode
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    mask_d    = mask_q;
    buf_d     = buf_q;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    words_d   = words_q;
    done_d    = done_q;
    full_d    = full_q;
    csb0_d    = 1'b1;
    web0_d    = 1'b1;
    wmask0_d  = '0;
    addr0_d   = addr0_q;
    din0_d    = din0_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FILL;
          lane_d    = '0;
          mask_d    = '0;
          buf_d     = '0;
          last_d    = 1'b0;
          wr_addr_d = '0;
          words_d   = '0;
          done_d    = 1'b0;
          full_d    = 1'b0;
        end
      end
      S_FILL: begin
        if (accept) begin
          buf_d[8*int'(lane_q) +: 8] = in_data;
          mask_d[lane_q]             = 1'b1;
          if (lane_q == LANE_MAX || in_last) begin
            // Strobe registered on the handshake edge so it is live during WRITE
            state_d  = S_WRITE;
            last_d   = in_last;
            csb0_d   = 1'b0;
            web0_d   = 1'b0;
            addr0_d  = wr_addr_q;
            din0_d   = buf_d;
            wmask0_d = mask_d;
          end else begin
            lane_d = LANE_W'(lane_q + 1'b1);
          end
        end
      end
      S_WRITE: begin
        lane_d    = '0;
        mask_d    = '0;
        buf_d     = '0;
        wr_addr_d = ADDR_WIDTH'(wr_addr_q + 1'b1);
        words_d   = (words_q == WORDS_MAX) ? words_q : CNT_W'(words_q + 1'b1);
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wr_addr_q == ADDR_MAX) begin
`ifdef SRAM_WRITER_WRAP_EN
          state_d = S_FILL;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          full_d  = 1'b1;
`endif
        end else begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_FILL);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q     <= '0;
      mask_q     <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      wr_addr_q  <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      wmask0_q   <= '0;
      addr0_q    <= '0;
      din0_q     <= '0;
    end else begin
      lane_q     <= lane_d;
      mask_q     <= mask_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      wr_addr_q  <= wr_addr_d;
      words_q    <= words_d;
      done_q     <= done_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      wmask0_q   <= wmask0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign csb0          = csb0_q;
  assign web0          = web0_q;
  assign wmask0        = wmask0_q;
  assign addr0         = addr0_q;
  assign din0          = din0_q;
  assign words_written = words_q;
  assign done          = done_q;
  assign full          = full_q;

endmodule

// File: tb/tb_sram_stream_writer.sv
// Directed bench for sram_stream_writer; covers both SRAM_WRITER_WRAP_EN builds.
module tb_sram_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, csb0, web0, done, full;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [8:0]  words_written;

  int checks = 0;
  int passed = 0;
  int low_cnt = 0;
  int viol = 0;
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wm_q[$];

  always #5 clk = ~clk;

  sram_stream_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .words_written(words_written), .done(done), .full(full)
  );

  // Record what the SRAM would sample at each edge
  always @(posedge clk) begin
    if (csb0 === 1'b0) begin
      low_cnt++;
      if (in_ready === 1'b1) viol++;
      if (web0 === 1'b0) begin
        wa_q.push_back(addr0);
        wd_q.push_back(din0);
        wm_q.push_back(wmask0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    step(); step();
    rst_n = 1'b1;
    wa_q.delete(); wd_q.delete(); wm_q.delete();
    low_cnt = 0; viol = 0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({csb0, web0} !== 2'b11) $display("FAIL rst_strobe: got %b req 11", {csb0, web0}); else passed++;
    checks++; if ({wmask0, addr0, din0} !== 44'h0) $display("FAIL rst_bus: got %h req 0", {wmask0, addr0, din0}); else passed++;
    checks++; if ({in_ready, done, full, words_written} !== 12'h0) $display("FAIL rst_status: got %h req 0", {in_ready, done, full, words_written}); else passed++;
  endtask

  task automatic test_full_word(input logic l);
    do_reset();
    do_start();
    checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready: got %b req 1", in_ready); else passed++;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, l);
    checks++; if ({csb0, web0, addr0} !== 10'h000) $display("FAIL word_strobe: got %h req 000", {csb0, web0, addr0}); else passed++;
    checks++; if (din0 !== 32'h44332211) $display("FAIL word_din: got %h req 44332211", din0); else passed++;
    checks++; if (wmask0 !== 4'hF) $display("FAIL word_mask: got %h req f", wmask0); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL write_ready: got %b req 0", in_ready); else passed++;
    step();
    checks++; if ({csb0, web0, wmask0} !== 6'b110000) $display("FAIL word_release: got %b req 110000", {csb0, web0, wmask0}); else passed++;
    checks++; if ({done, words_written} !== {l, 9'd1}) $display("FAIL word_status: got %h req %h", {done, words_written}, {l, 9'd1}); else passed++;
  endtask

  task automatic test_partial();
    do_reset();
    do_start();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    checks++; if ({csb0, addr0, din0, wmask0} !== {1'b0, 8'd0, 32'hDDCCBBAA, 4'hF}) $display("FAIL part_w0: got %h req %h", {csb0, addr0, din0, wmask0}, {1'b0, 8'd0, 32'hDDCCBBAA, 4'hF}); else passed++;
    send(8'hEE, 1'b1);
    checks++; if ({csb0, addr0, din0, wmask0} !== {1'b0, 8'd1, 32'h000000EE, 4'b0001}) $display("FAIL part_w1: got %h req %h", {csb0, addr0, din0, wmask0}, {1'b0, 8'd1, 32'h000000EE, 4'b0001}); else passed++;
    step();
    checks++; if ({done, full, in_ready, words_written} !== {3'b100, 9'd2}) $display("FAIL part_status: got %h req %h", {done, full, in_ready, words_written}, {3'b100, 9'd2}); else passed++;
  endtask

  task automatic test_gaps();
    int ok;
    do_reset();
    do_start();
    for (int i = 0; i < 32; i++) begin
      send(8'(i * 7 + 3), i == 31);
      repeat ((i * 5) % 3) step();
    end
    repeat (3) step();
    checks++; if (wa_q.size() !== 8) $display("FAIL gap_count: got %0d writes req 8", wa_q.size()); else passed++;
    ok = 1;
    for (int w = 0; w < 8 && w < wa_q.size(); w++) begin
      logic [31:0] exp_d;
      for (int b = 0; b < 4; b++) exp_d[8*b +: 8] = 8'((4 * w + b) * 7 + 3);
      if (wa_q[w] !== 8'(w) || wd_q[w] !== exp_d || wm_q[w] !== 4'hF) begin
        ok = 0;
        $display("FAIL gap_word%0d: got addr %h din %h mask %h req addr %h din %h mask f", w, wa_q[w], wd_q[w], wm_q[w], 8'(w), exp_d);
      end
    end
    checks++; if (ok == 1) passed++;
    checks++; if (low_cnt !== 8) $display("FAIL gap_csb_cycles: got %0d req 8", low_cnt); else passed++;
    checks++; if (viol !== 0) $display("FAIL gap_csb_in_fill: got %0d req 0", viol); else passed++;
    checks++; if ({done, words_written} !== {1'b1, 9'd8}) $display("FAIL gap_status: got %h req %h", {done, words_written}, {1'b1, 9'd8}); else passed++;
  endtask

  task automatic test_start_ignored();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    step();
    do_start();
    for (int i = 4; i < 8; i++) send(8'(i + 1), i == 7);
    step();
    checks++; if (wa_q.size() !== 2 || wa_q[0] !== 8'd0 || wa_q[1] !== 8'd1) $display("FAIL start_fill_addrs: got %0d writes, req addrs 0,1", wa_q.size()); else passed++;
    checks++; if (wd_q.size() == 2 && wd_q[1] !== 32'h08070605) $display("FAIL start_fill_din: got %h req 08070605", wd_q[1]); else if (wd_q.size() == 2) passed++;
    do_start();
    checks++; if ({done, words_written} !== 10'h0) $display("FAIL restart_status: got %h req 0", {done, words_written}); else passed++;
    send(8'h5A, 1'b1);
    checks++; if ({csb0, addr0, din0, wmask0} !== {1'b0, 8'd0, 32'h0000005A, 4'b0001}) $display("FAIL restart_write: got %h req %h", {csb0, addr0, din0, wmask0}, {1'b0, 8'd0, 32'h0000005A, 4'b0001}); else passed++;
  endtask

  task automatic test_fill_memory();
    do_reset();
    do_start();
    for (int i = 0; i < 1024; i++) send(8'(i), 1'b0);
    checks++; if ({csb0, addr0, din0} !== {1'b0, 8'hFF, 32'hFFFEFDFC}) $display("FAIL mem_last_write: got %h req %h", {csb0, addr0, din0}, {1'b0, 8'hFF, 32'hFFFEFDFC}); else passed++;
    step();
    checks++; if (wa_q.size() !== 256) $display("FAIL mem_write_count: got %0d req 256", wa_q.size()); else passed++;
    checks++; if (words_written !== 9'd256) $display("FAIL mem_words: got %0d req 256", words_written); else passed++;
`ifdef SRAM_WRITER_WRAP_EN
    checks++; if ({done, full, in_ready} !== 3'b001) $display("FAIL wrap_status: got %b req 001", {done, full, in_ready}); else passed++;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0);
    checks++; if ({csb0, addr0, din0} !== {1'b0, 8'h00, 32'hC3C2C1C0}) $display("FAIL wrap_write: got %h req %h", {csb0, addr0, din0}, {1'b0, 8'h00, 32'hC3C2C1C0}); else passed++;
    step();
    checks++; if ({full, words_written} !== {1'b0, 9'd256}) $display("FAIL wrap_words: got %h req %h", {full, words_written}, {1'b0, 9'd256}); else passed++;
`else
    checks++; if ({done, full, in_ready} !== 3'b110) $display("FAIL full_status: got %b req 110", {done, full, in_ready}); else passed++;
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) step();
    in_valid = 1'b0;
    checks++; if (wa_q.size() !== 256 || in_ready !== 1'b0) $display("FAIL full_blocked: got %0d writes ready %b req 256 ready 0", wa_q.size(), in_ready); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    send(8'hE1, 1'b0); send(8'hE2, 1'b0);
    rst_n = 1'b0;
    step();
    checks++; if ({csb0, in_ready, done} !== 3'b100) $display("FAIL midrst_state: got %b req 100", {csb0, in_ready, done}); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b0) $display("FAIL midrst_idle: in_ready got %b req 0", in_ready); else passed++;
    do_start();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    checks++; if ({csb0, addr0, din0, wmask0} !== {1'b0, 8'd0, 32'h04030201, 4'hF}) $display("FAIL midrst_write: got %h req %h", {csb0, addr0, din0, wmask0}, {1'b0, 8'd0, 32'h04030201, 4'hF}); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_word(1'b0);
    test_full_word(1'b1);
    test_partial();
    test_gaps();
    test_start_ignored();
    test_fill_memory();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
